// File: rtl/sodor5_imem_responder_if.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// sodor5_imem_responder_if
// Fetch request/response bundle between the Sodor 5-stage core (master) and
// its instruction-memory responder (slave).
//   io_imem_req_valid       core -> mem  fetch request valid
//   io_imem_req_ready       mem  -> core responder can accept this cycle
//   io_imem_req_bits_addr   core -> mem  byte fetch address
//   io_imem_resp_valid      mem  -> core response word valid
//   io_imem_resp_ready      core -> mem  core consumes response this cycle
//   io_imem_resp_bits_data  mem  -> core instruction word
//   io_imem_resp_bits_err   mem  -> core request address was misaligned
// -----------------------------------------------------------------------------
interface sodor5_imem_responder_if;
   logic        io_imem_req_valid;
   logic        io_imem_req_ready;
   logic [31:0] io_imem_req_bits_addr;
   logic        io_imem_resp_valid;
   logic        io_imem_resp_ready;
   logic [31:0] io_imem_resp_bits_data;
   logic        io_imem_resp_bits_err;

   modport master (
      output io_imem_req_valid,
      output io_imem_req_bits_addr,
      output io_imem_resp_ready,
      input  io_imem_req_ready,
      input  io_imem_resp_valid,
      input  io_imem_resp_bits_data,
      input  io_imem_resp_bits_err
   );

   modport slave (
      input  io_imem_req_valid,
      input  io_imem_req_bits_addr,
      input  io_imem_resp_ready,
      output io_imem_req_ready,
      output io_imem_resp_valid,
      output io_imem_resp_bits_data,
      output io_imem_resp_bits_err
   );
endinterface

// File: rtl/sodor5_imem_responder.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// sodor5_imem_responder
// Instruction-memory responder for the Sodor 5-stage core. Fetch requests are
// looked up in a small program store, carried through a LATENCY-deep pipeline
// and queued in a FIFO_DEPTH-entry response buffer. Requests are only accepted
// while a response slot is guaranteed (credit = pipeline + buffer occupancy),
// so a word leaving the pipeline always finds room in the buffer.
// Ports:
//   clk        core clock
//   reset      synchronous, active-low reset (0 = reset asserted)
//   prog_we    program store write enable (honoured even during reset)
//   prog_idx   program store write index
//   prog_data  program store write data
//   imem       fetch request/response bundle (slave side)
//   req_count  accepted-request counter, wraps at 2^32
// -----------------------------------------------------------------------------
module sodor5_imem_responder #(
   parameter int          NUM_WORDS  = 16,
   parameter int          LATENCY    = 1,
   parameter int          FIFO_DEPTH = 4,
   parameter logic [31:0] NOP_WORD   = 32'h00000013
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         prog_we,
   input  logic [$clog2(NUM_WORDS)-1:0] prog_idx,
   input  logic [31:0]                  prog_data,
   sodor5_imem_responder_if.slave       imem,
   output logic [31:0]                  req_count
);

   localparam int IDX_W = $clog2(NUM_WORDS);
   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam logic [CNT_W:0]   DEPTH_C  = (CNT_W + 1)'(FIFO_DEPTH);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);

   // Program store: never reset, written straight from the load port.
   logic [31:0] store_mem [NUM_WORDS];

   // Control state (reset)
   logic [LATENCY-1:0]          pipe_vld_q,  pipe_vld_d;
   logic [PTR_W-1:0]            wr_ptr_q,    wr_ptr_d;
   logic [PTR_W-1:0]            rd_ptr_q,    rd_ptr_d;
   logic [CNT_W-1:0]            fifo_cnt_q,  fifo_cnt_d;
   logic [CNT_W-1:0]            inflight_q,  inflight_d;
   logic [31:0]                 req_count_q, req_count_d;

   // Data state (not reset; qualified by the control bits above)
   logic [LATENCY-1:0][31:0]    pipe_data_q, pipe_data_d;
   logic [LATENCY-1:0]          pipe_err_q,  pipe_err_d;
   logic [FIFO_DEPTH-1:0][31:0] fifo_data_q, fifo_data_d;
   logic [FIFO_DEPTH-1:0]       fifo_err_q,  fifo_err_d;

   logic [IDX_W-1:0] req_idx;
   logic             req_misaligned;
   logic [31:0]      lookup_data;
   logic [CNT_W:0]   occupancy;
   logic             accept;
   logic             push;
   logic             pop;
   logic             resp_valid;
   logic             unused_addr_bits;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
   endfunction

   // Upper address bits do not select anything; the index wraps modulo NUM_WORDS.
   assign req_idx          = imem.io_imem_req_bits_addr[IDX_W+1:2];
   assign req_misaligned   = |imem.io_imem_req_bits_addr[1:0];
   assign unused_addr_bits = ^imem.io_imem_req_bits_addr[31:IDX_W+2];

   // Combinational read of the store: on a same-cycle write to the same index
   // the request captures the pre-write word.
   assign lookup_data = req_misaligned ? NOP_WORD : store_mem[req_idx];

   // Credit check depends only on counters, never on req_valid.
   assign occupancy              = {1'b0, fifo_cnt_q} + {1'b0, inflight_q};
   assign imem.io_imem_req_ready = reset && (occupancy < DEPTH_C);
   assign accept                 = imem.io_imem_req_valid && imem.io_imem_req_ready;

   assign push = pipe_vld_q[LATENCY-1];

   // Buffered words are hidden while reset is asserted so nothing partial escapes.
   assign resp_valid              = reset && (fifo_cnt_q != '0);
   assign pop                     = resp_valid && imem.io_imem_resp_ready;
   assign imem.io_imem_resp_valid = resp_valid;
   assign imem.io_imem_resp_bits_data = resp_valid ? fifo_data_q[rd_ptr_q] : NOP_WORD;
   assign imem.io_imem_resp_bits_err  = resp_valid && fifo_err_q[rd_ptr_q];

   assign req_count = req_count_q;

   always_comb begin
      // Lookup pipeline: stage 0 captures on the acceptance edge.
      pipe_vld_d     = pipe_vld_q;
      pipe_data_d    = pipe_data_q;
      pipe_err_d     = pipe_err_q;
      pipe_vld_d[0]  = accept;
      pipe_data_d[0] = lookup_data;
      pipe_err_d[0]  = req_misaligned;
      for (int i = 1; i < LATENCY; i++) begin
         pipe_vld_d[i]  = pipe_vld_q[i-1];
         pipe_data_d[i] = pipe_data_q[i-1];
         pipe_err_d[i]  = pipe_err_q[i-1];
      end

      // Response buffer: every pipeline exit is written, no bypass path.
      fifo_data_d = fifo_data_q;
      fifo_err_d  = fifo_err_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      if (push) begin
         fifo_data_d[wr_ptr_q] = pipe_data_q[LATENCY-1];
         fifo_err_d[wr_ptr_q]  = pipe_err_q[LATENCY-1];
         wr_ptr_d              = ptr_inc(wr_ptr_q);
      end
      if (pop) begin
         rd_ptr_d = ptr_inc(rd_ptr_q);
      end

      // Counters: full/empty come from fifo_cnt, not from pointer equality.
      fifo_cnt_d  = fifo_cnt_q + CNT_W'(push) - CNT_W'(pop);
      inflight_d  = inflight_q + CNT_W'(accept) - CNT_W'(push);
      req_count_d = req_count_q + 32'(accept);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         pipe_vld_q  <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         fifo_cnt_q  <= '0;
         inflight_q  <= '0;
         req_count_q <= '0;
      end else begin
         pipe_vld_q  <= pipe_vld_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         fifo_cnt_q  <= fifo_cnt_d;
         inflight_q  <= inflight_d;
         req_count_q <= req_count_d;
      end
      pipe_data_q <= pipe_data_d;
      pipe_err_q  <= pipe_err_d;
      fifo_data_q <= fifo_data_d;
      fifo_err_q  <= fifo_err_d;
   end

   always_ff @(posedge clk) begin
      if (prog_we) begin
         store_mem[prog_idx] <= prog_data;
      end
   end

endmodule

// File: tb/tb_sodor5_imem_responder.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_sodor5_imem_responder
// Three responders (LATENCY 1, 2, 3) share one stimulus stream; sel picks the
// instance whose outputs are compared in each scenario.
// -----------------------------------------------------------------------------
module tb_sodor5_imem_responder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        prog_we;
   logic [3:0]  prog_idx;
   logic [31:0] prog_data;
   logic        req_valid;
   logic [31:0] req_addr;
   logic        resp_ready;
   logic [31:0] cnt1, cnt2, cnt3;

   sodor5_imem_responder_if ifc1 ();
   sodor5_imem_responder_if ifc2 ();
   sodor5_imem_responder_if ifc3 ();

   assign ifc1.io_imem_req_valid     = req_valid;
   assign ifc1.io_imem_req_bits_addr = req_addr;
   assign ifc1.io_imem_resp_ready    = resp_ready;
   assign ifc2.io_imem_req_valid     = req_valid;
   assign ifc2.io_imem_req_bits_addr = req_addr;
   assign ifc2.io_imem_resp_ready    = resp_ready;
   assign ifc3.io_imem_req_valid     = req_valid;
   assign ifc3.io_imem_req_bits_addr = req_addr;
   assign ifc3.io_imem_resp_ready    = resp_ready;

   sodor5_imem_responder #(.NUM_WORDS(16), .LATENCY(1), .FIFO_DEPTH(4), .NOP_WORD(32'h00000013)) dut1 (
      .clk(clk), .reset(rst_n), .prog_we(prog_we), .prog_idx(prog_idx),
      .prog_data(prog_data), .imem(ifc1), .req_count(cnt1));
   sodor5_imem_responder #(.NUM_WORDS(16), .LATENCY(2), .FIFO_DEPTH(4), .NOP_WORD(32'h00000013)) dut2 (
      .clk(clk), .reset(rst_n), .prog_we(prog_we), .prog_idx(prog_idx),
      .prog_data(prog_data), .imem(ifc2), .req_count(cnt2));
   sodor5_imem_responder #(.NUM_WORDS(16), .LATENCY(3), .FIFO_DEPTH(4), .NOP_WORD(32'h00000013)) dut3 (
      .clk(clk), .reset(rst_n), .prog_we(prog_we), .prog_idx(prog_idx),
      .prog_data(prog_data), .imem(ifc3), .req_count(cnt3));

   int          sel;
   logic        o_ready, o_valid, o_err;
   logic [31:0] o_data, o_cnt;

   always_comb begin
      o_ready = ifc1.io_imem_req_ready;
      o_valid = ifc1.io_imem_resp_valid;
      o_data  = ifc1.io_imem_resp_bits_data;
      o_err   = ifc1.io_imem_resp_bits_err;
      o_cnt   = cnt1;
      if (sel == 2) begin
         o_ready = ifc2.io_imem_req_ready;
         o_valid = ifc2.io_imem_resp_valid;
         o_data  = ifc2.io_imem_resp_bits_data;
         o_err   = ifc2.io_imem_resp_bits_err;
         o_cnt   = cnt2;
      end else if (sel == 3) begin
         o_ready = ifc3.io_imem_req_ready;
         o_valid = ifc3.io_imem_resp_valid;
         o_data  = ifc3.io_imem_resp_bits_data;
         o_err   = ifc3.io_imem_resp_bits_err;
         o_cnt   = cnt3;
      end
   end

   int          n_chk  = 0;
   int          n_pass = 0;
   logic [31:0] mstore [16];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
   endtask

   // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic prog(input int idx, input logic [31:0] d);
      prog_we   = 1'b1;
      prog_idx  = idx[3:0];
      prog_data = d;
      tick();
      prog_we     = 1'b0;
      mstore[idx] = d;
   endtask

   task automatic do_reset();
      req_valid = 1'b0;
      rst_n     = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   initial begin
      int          issued;
      int          popped;
      logic        fire;
      logic        stalled;
      logic [31:0] held;

      rst_n = 1'b0; prog_we = 1'b0; prog_idx = '0; prog_data = '0;
      req_valid = 1'b0; req_addr = '0; resp_ready = 1'b1; sel = 1;
      tick();
      check("rst_ready_low", 32'(o_ready), 32'd0);
      check("rst_valid_low", 32'(o_valid), 32'd0);

      // Program load happens while reset is still asserted.
      for (int i = 0; i < 16; i++) prog(i, 32'h00000033 + (i << 7));
      rst_n = 1'b1;
      tick();
      check("post_rst_ready", 32'(o_ready), 32'd1);
      check("post_rst_valid", 32'(o_valid), 32'd0);
      check("post_rst_data",  o_data,       32'h00000013);
      check("post_rst_err",   32'(o_err),   32'd0);
      check("post_rst_cnt",   o_cnt,        32'd0);

      // 1: back-to-back fetches, LATENCY=1
      sel = 1; resp_ready = 1'b1;
      for (int c = 0; c < 19; c++) begin
         if (c >= 2 && c <= 17) begin
            check("t1_valid", 32'(o_valid), 32'd1);
            check("t1_data",  o_data, 32'h00000033 + ((c - 2) << 7));
            check("t1_err",   32'(o_err), 32'd0);
         end
         if (c < 16) begin
            check("t1_ready", 32'(o_ready), 32'd1);
            req_valid = 1'b1;
            req_addr  = c * 4;
         end else begin
            req_valid = 1'b0;
         end
         tick();
      end
      check("t1_count",   o_cnt,        32'd16);
      check("t1_drained", 32'(o_valid), 32'd0);

      // 2: index wrap and misaligned address
      req_valid = 1'b1; req_addr = 32'h00000044; tick();
      req_addr = 32'h00000006; tick();
      check("t2_wrap_valid", 32'(o_valid), 32'd1);
      check("t2_wrap_data",  o_data,       32'h000000B3);
      check("t2_wrap_err",   32'(o_err),   32'd0);
      req_valid = 1'b0; tick();
      check("t2_mis_valid", 32'(o_valid), 32'd1);
      check("t2_mis_data",  o_data,       32'h00000013);
      check("t2_mis_err",   32'(o_err),   32'd1);
      tick();
      check("t2_drained", 32'(o_valid), 32'd0);

      // 3: backpressure fills the credit window
      do_reset();
      sel = 1; resp_ready = 1'b0;
      for (int c = 0; c < 8; c++) begin
         check("t3_ready", 32'(o_ready), (c < 4) ? 32'd1 : 32'd0);
         if (c >= 2) check("t3_hold_data", o_data, mstore[0]);
         req_valid = 1'b1;
         req_addr  = c * 4;
         tick();
      end
      check("t3_count", o_cnt,        32'd4);
      check("t3_valid", 32'(o_valid), 32'd1);
      req_valid = 1'b0; resp_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         check("t3_drain_valid", 32'(o_valid), 32'd1);
         check("t3_drain_data",  o_data,       mstore[k]);
         tick();
         if (k == 0) check("t3_ready_back", 32'(o_ready), 32'd1);
      end
      check("t3_empty", 32'(o_valid), 32'd0);

      // 4: store write colliding with a fetch of the same word
      sel = 1; resp_ready = 1'b1;
      prog_we = 1'b1; prog_idx = 4'd3; prog_data = 32'hDEADBEEF;
      req_valid = 1'b1; req_addr = 32'd12;
      tick();
      prog_we = 1'b0; mstore[3] = 32'hDEADBEEF;
      tick();
      check("t4_old_valid", 32'(o_valid), 32'd1);
      check("t4_old_word",  o_data,       32'h000001B3);
      req_valid = 1'b0;
      tick();
      check("t4_new_valid", 32'(o_valid), 32'd1);
      check("t4_new_word",  o_data,       32'hDEADBEEF);
      tick();

      // 5: reset with three fetches in flight, LATENCY=3
      do_reset();
      sel = 3; resp_ready = 1'b1;
      req_valid = 1'b1;
      for (int c = 0; c < 3; c++) begin
         req_addr = c * 4;
         tick();
      end
      check("t5_count_pre", o_cnt, 32'd3);
      req_valid = 1'b0; rst_n = 1'b0;
      #1;
      check("t5_rst_ready", 32'(o_ready), 32'd0);
      check("t5_rst_valid", 32'(o_valid), 32'd0);
      tick();
      rst_n = 1'b1;
      check("t5_count_clr", o_cnt, 32'd0);
      for (int c = 0; c < 4; c++) begin
         check("t5_no_resp", 32'(o_valid), 32'd0);
         tick();
      end
      req_valid = 1'b1; req_addr = 32'd0;
      tick();
      req_valid = 1'b0;
      tick();
      check("t5_lat_1", 32'(o_valid), 32'd0);
      tick();
      check("t5_lat_2", 32'(o_valid), 32'd0);
      tick();
      check("t5_lat_3",      32'(o_valid), 32'd1);
      check("t5_store_kept", o_data,       32'h00000033);
      check("t5_count",      o_cnt,        32'd1);
      tick();

      // 6: toggling resp_ready, LATENCY=2
      do_reset();
      sel = 2;
      issued = 0; popped = 0;
      for (int c = 0; c < 60 && popped < 8; c++) begin
         resp_ready = (c % 2 == 0);
         stalled    = o_valid && !resp_ready;
         held       = o_data;
         if (o_valid && resp_ready) begin
            check("t6_order", o_data, mstore[popped]);
            popped++;
         end
         if (issued < 8) begin
            req_valid = 1'b1;
            req_addr  = issued * 4;
         end else begin
            req_valid = 1'b0;
         end
         fire = req_valid && o_ready;
         tick();
         if (fire) issued++;
         check("t6_outstanding", 32'((issued - popped) <= 4), 32'd1);
         if (stalled) check("t6_stall_hold", o_data, held);
      end
      req_valid = 1'b0;
      check("t6_issued", 32'(issued), 32'd8);
      check("t6_popped", 32'(popped), 32'd8);
      check("t6_count",  o_cnt,       32'd8);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/sodor5_imem_responder.md
Name: sodor5_imem_responder

Overview:
- Instruction-memory responder for the Sodor 5-stage core's imem port.
- Accepts fetch requests from the core and looks up the word at the requested address in a small program store, which the bench loads before the run.
- Returns each word after a fixed latency through a small response buffer with backpressure.
- Replaces free-running instruction injection: the core now pulls instructions by address, so branches and stalls are exercised against a real fetch protocol.

Parameters:
NUM_WORDS, 16, program store depth in 32-bit words; power of 2
LATENCY, 1, request-to-response pipeline depth in cycles; legal range 1..4
FIFO_DEPTH, 4, response buffer entries; power of 2, must be >= LATENCY
NOP_WORD, 32'h00000013, word returned during reset drain and for misaligned requests

Ports:
clk  in  1  core clock
reset  in  1  synchronous, active-low reset (0 = reset asserted)
prog_we  in  1  program store write enable
prog_idx  in  log2(NUM_WORDS)  program store write index
prog_data  in  32  program store write data
io_imem_req_valid  in  1  core fetch request valid
io_imem_req_ready  out  1  responder can accept a request this cycle
io_imem_req_bits_addr  in  32  byte fetch address
io_imem_resp_valid  out  1  response word valid
io_imem_resp_ready  in  1  core consumes response this cycle
io_imem_resp_bits_data  out  32  instruction word
io_imem_resp_bits_err  out  1  request address was misaligned
req_count  out  32  accepted-request counter, for trace alignment

Behaviour:
- Reset (reset==0 at a clk edge) has the following effects:
  - Clears pipeline valid bits, FIFO pointers and occupancy, in-flight count and req_count.
  - Outputs after reset: req_ready=0 during reset, then 1 on the first cycle out of reset; resp_valid=0; resp_bits_data=NOP_WORD; resp_bits_err=0; req_count=0.
  - Program store is NOT cleared; prog writes are honoured even during reset.
  - Reset mid-operation drops all in-flight and buffered responses; nothing partial is emitted.
- Request acceptance: a request is accepted when req_valid && req_ready at the clk edge.
  - Word index = addr[log2(NUM_WORDS)+1:2], wrapping modulo NUM_WORDS. Upper address bits are ignored.
  - If addr[1:0]!=0, the response data is NOP_WORD and err=1. Otherwise data = store[index] and err=0.
- Store sampling and write collision: the store is sampled on the acceptance edge. If prog_we targets the same index on the same cycle, the response carries the OLD word and the new word is visible to later requests.
- Latency: an accepted request enters a LATENCY-stage valid/data shift pipeline, then the FIFO. With an empty FIFO and resp_ready=1, resp_valid rises exactly LATENCY cycles after the acceptance edge.
- Ordering: responses are strictly in request order; no reordering or dropping.
- Credit flow control:
  - occupancy = in-flight pipeline entries + FIFO entries.
  - req_ready = (occupancy < FIFO_DEPTH). This is registered-free combinational from counters, not from req_valid.
  - A pop and an accept in the same cycle leave occupancy unchanged; this is what allows full throughput at one request per cycle.
- Response handshake:
  - resp_valid = FIFO non-empty; data and err come from the FIFO head.
  - The word is popped on resp_valid && resp_ready.
  - While resp_valid=1 and resp_ready=0, data and err hold stable.
  - Full FIFO: a pipeline entry can never arrive at a full FIFO, because credit accounting guarantees it.
- Empty-FIFO case: if resp_ready=1 and the FIFO is empty, the word still enters the FIFO first; there is no bypass. Latency stays exactly LATENCY.
- Pointer wrap: FIFO pointers are modulo FIFO_DEPTH. Full and empty are distinguished by an occupancy counter, not by pointer equality.
- req_count: increments by 1 per accepted request and wraps from 2^32-1 to 0.

Test Plan:
1. Load store[i]=32'h00000033+(i<<7) for i=0..15. Issue back-to-back requests for addr 0,4,...,60 with resp_ready=1 and LATENCY=1. Expect 16 responses in order, each one cycle after its acceptance, req_ready constantly 1, and req_count=16.
2. Request addr 32'h00000044. Expect the response to be store[1] (index wraps) with err=0. Request addr 32'h00000006. Expect data 32'h00000013 and err=1.
3. Hold resp_ready=0 and issue requests continuously. Expect exactly 4 acceptances, then req_ready=0 and resp_valid=1 with data held stable. Raise resp_ready. Expect 4 ordered responses, and req_ready returns 1 on the first pop cycle.
4. On one cycle, set prog_we=1, prog_idx=3, prog_data=32'hDEADBEEF and accept a request for addr 12 (old store[3]=32'h000001B3). Expect that response to be 32'h000001B3 and the next request for addr 12 to return 32'hDEADBEEF.
5. With LATENCY=3, accept 3 requests, then drive reset=0 for one cycle before any response. Expect no resp_valid afterwards, req_count=0, and store contents intact: a fresh request for addr 0 returns the pre-reset store[0] three cycles later.
6. With LATENCY=2 and resp_ready toggling 1,0,1,0, issue 8 requests. Expect all 8 responses in order, never more than 4 outstanding, and no data change while stalled.
